// File: rtl/arbitro_controles_if.sv
// arbitro_controles_if: control-source arbiter bus.
// Raw source requests and mode in, selected move commands out.
interface arbitro_controles_if #(
  parameter int NUM_FUENTES = 3,
  parameter int SEL_W       = 2
);
  logic [SEL_W-1:0]       selector;
  logic [NUM_FUENTES-1:0] entradaDer;
  logic [NUM_FUENTES-1:0] entradaIzq;
  logic [1:0]             modo;
  logic                   salidaDerecha;
  logic                   salidaIzquierda;
  logic [SEL_W-1:0]       fuenteActiva;
  logic                   cambiando;

  modport master (
    output selector,
    output entradaDer,
    output entradaIzq,
    output modo,
    input  salidaDerecha,
    input  salidaIzquierda,
    input  fuenteActiva,
    input  cambiando
  );

  modport slave (
    input  selector,
    input  entradaDer,
    input  entradaIzq,
    input  modo,
    output salidaDerecha,
    output salidaIzquierda,
    output fuenteActiva,
    output cambiando
  );
endinterface

// File: rtl/arbitro_controles.sv
// arbitro_controles: N-source left/right control arbiter.
// Sync, debounce, guard on source change, level/one-shot/repeat.
module arbitro_controles #(
  parameter int NUM_FUENTES     = 3,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int GUARDA_CICLOS   = 4,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input logic               clk,
  input logic               rst_n,
  arbitro_controles_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int GD_W = $clog2(GUARDA_CICLOS + 1);
  localparam int RP_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W = $clog2(RP_MAX + 1);

  localparam logic [SEL_W:0] NF_L = (SEL_W+1)'(NUM_FUENTES);
  localparam logic [DB_W-1:0] DB_FIN = DB_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [GD_W-1:0] GD_FIN = GD_W'(GUARDA_CICLOS);
  localparam logic [RP_W-1:0] RP_DEL = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PER = RP_W'(REPEAT_PERIOD);

  typedef enum logic {
    ACTIVO,
    GUARDA
  } estado_t;

  logic [NUM_FUENTES-1:0] der_m, der_s;
  logic [NUM_FUENTES-1:0] izq_m, izq_s;

  logic [SEL_W-1:0] sel_ef;

  estado_t          estado_q, estado_d;
  logic [SEL_W-1:0] fuente_q, fuente_d;
  logic [GD_W-1:0]  guarda_q, guarda_d;
  logic             limpiar;

  // index 0 = right, index 1 = left
  logic [1:0]      raw;
  logic [1:0]      deb_q;
  logic [DB_W-1:0] cnt_q [2];

  logic [1:0]      pr;
  logic [1:0]      prev_q;
  logic [1:0]      flanco;
  logic [1:0]      sal_q, sal_d;
  logic [1:0]      fase_q, fase_d;
  logic [RP_W-1:0] rep_q [2];
  logic [RP_W-1:0] rep_d [2];
  logic [1:0]      modo_q;
  logic            modo_cambio;
  logic            modo_uno;
  logic            modo_rep;

  // two-flop synchronisers on every raw request bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      der_m <= '0;
      der_s <= '0;
      izq_m <= '0;
      izq_s <= '0;
    end else begin
      der_m <= bus.entradaDer;
      der_s <= der_m;
      izq_m <= bus.entradaIzq;
      izq_s <= izq_m;
    end
  end

  // out-of-range selections fall back to the buttons
  always_comb begin
    sel_ef = '0;
    if ({1'b0, bus.selector} < NF_L) begin
      sel_ef = bus.selector;
    end
  end

  // source-change FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ACTIVO;
      fuente_q <= '0;
      guarda_q <= '0;
    end else begin
      estado_q <= estado_d;
      fuente_q <= fuente_d;
      guarda_q <= guarda_d;
    end
  end

  // guard window: reloads on every further change
  always_comb begin
    estado_d = estado_q;
    fuente_d = fuente_q;
    guarda_d = guarda_q;
    limpiar  = 1'b0;
    unique case (estado_q)
      ACTIVO: begin
        if (sel_ef != fuente_q) begin
          fuente_d = sel_ef;
          guarda_d = GD_W'(1);
          estado_d = GUARDA;
          limpiar  = 1'b1;
        end
      end
      GUARDA: begin
        limpiar = 1'b1;
        if (sel_ef != fuente_q) begin
          fuente_d = sel_ef;
          guarda_d = GD_W'(1);
        end else if (guarda_q == GD_FIN) begin
          estado_d = ACTIVO;
          guarda_d = '0;
        end else begin
          guarda_d = guarda_q + 1'b1;
        end
      end
      default: begin
        estado_d = ACTIVO;
      end
    endcase
  end

  // pick the synchronised pair of the active source
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_FUENTES; i++) begin
      if (fuente_q == SEL_W'(i)) begin
        raw = {izq_s[i], der_s[i]};
      end
    end
  end

  // debounce: level flips after DEBOUNCE_CICLOS mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else if (limpiar) begin
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (raw[d] == deb_q[d]) begin
          cnt_q[d] <= '0;
        end else if (cnt_q[d] == DB_FIN) begin
          deb_q[d] <= raw[d];
          cnt_q[d] <= '0;
        end else begin
          cnt_q[d] <= cnt_q[d] + 1'b1;
        end
      end
    end
  end

  assign modo_uno    = (bus.modo == 2'b01);
  assign modo_rep    = (bus.modo == 2'b10);
  assign modo_cambio = (bus.modo != modo_q);

  // both held counts as none; mode selects output shaping
  always_comb begin
    pr     = {deb_q[1] & ~deb_q[0], deb_q[0] & ~deb_q[1]};
    flanco = pr & ~prev_q;
    sal_d  = '0;
    fase_d = '0;
    rep_d[0] = '0;
    rep_d[1] = '0;
    for (int d = 0; d < 2; d++) begin
      unique case (1'b1)
        modo_uno: begin
          sal_d[d] = flanco[d];
        end
        modo_rep: begin
          if (flanco[d]) begin
            sal_d[d] = 1'b1;
            rep_d[d] = RP_W'(1);
          end else if (pr[d] && !modo_cambio) begin
            if (rep_q[d] == (fase_q[d] ? RP_PER : RP_DEL)) begin
              sal_d[d]  = 1'b1;
              rep_d[d]  = RP_W'(1);
              fase_d[d] = 1'b1;
            end else begin
              rep_d[d]  = rep_q[d] + 1'b1;
              fase_d[d] = fase_q[d];
            end
          end
        end
        default: begin
          sal_d[d] = pr[d];
        end
      endcase
    end
  end

  // registered outputs, edge history and repeat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sal_q    <= '0;
      prev_q   <= '0;
      fase_q   <= '0;
      rep_q[0] <= '0;
      rep_q[1] <= '0;
      modo_q   <= '0;
    end else begin
      modo_q <= bus.modo;
      if (limpiar) begin
        sal_q    <= '0;
        prev_q   <= '0;
        fase_q   <= '0;
        rep_q[0] <= '0;
        rep_q[1] <= '0;
      end else begin
        sal_q  <= sal_d;
        prev_q <= pr;
        fase_q <= fase_d;
        rep_q  <= rep_d;
      end
    end
  end

  assign bus.salidaDerecha   = sal_q[0];
  assign bus.salidaIzquierda = sal_q[1];
  assign bus.fuenteActiva    = fuente_q;
  assign bus.cambiando       = (estado_q == GUARDA);

endmodule

// File: tb/tb_arbitro_controles.sv
// tb_arbitro_controles: directed and random checks of the arbiter.
// Expected values come from timing arithmetic and a history model.
module tb_arbitro_controles;

  localparam int NF  = 3;
  localparam int SW  = 2;
  localparam int DB  = 16;
  localparam int GC  = 4;
  localparam int RD  = 1000;
  localparam int RPP = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  arbitro_controles_if #(.NUM_FUENTES(NF), .SEL_W(SW)) bus ();

  arbitro_controles #(
    .NUM_FUENTES(NF),
    .SEL_W(SW),
    .DEBOUNCE_CICLOS(DB),
    .GUARDA_CICLOS(GC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RPP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int sube[$];
  int baja[$];
  int expq[$];
  bit hd[$];
  bit hi[$];
  bit both1;
  bit camb_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one direction of one source high for `hold` edges, log edges
  task automatic run(input int src, input bit izq, input int hold,
                     input int total);
    logic last, cur;
    sube.delete();
    baja.delete();
    both1 = 1'b0;
    camb_seen = 1'b0;
    last = izq ? bus.salidaIzquierda : bus.salidaDerecha;
    for (int n = 1; n <= total; n++) begin
      if (izq) bus.entradaIzq[src] = (n <= hold);
      else     bus.entradaDer[src] = (n <= hold);
      tick();
      cur = izq ? bus.salidaIzquierda : bus.salidaDerecha;
      if (cur && !last) sube.push_back(n);
      if (!cur && last) baja.push_back(n);
      last = cur;
      if (bus.salidaDerecha && bus.salidaIzquierda) both1 = 1'b1;
      if (bus.cambiando) camb_seen = 1'b1;
    end
    if (izq) bus.entradaIzq[src] = 1'b0;
    else     bus.entradaDer[src] = 1'b0;
  endtask

  // debounced level flips once the last DB synchronised samples all equal v
  function automatic bit flips(input bit izq, input int n, input bit v);
    int idx;
    bit val;
    for (int k = 0; k < DB; k++) begin
      idx = n - 2 - k;
      if (idx < 1) val = 1'b0;
      else val = izq ? hi[idx-1] : hd[idx-1];
      if (val != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int rise, camb_cnt, camb_last, t, len, n;
    bit anyout, md, mi, dd, ii;
    logic [1:0] expo;

    bus.selector   = '0;
    bus.entradaDer = '0;
    bus.entradaIzq = '0;
    bus.modo       = 2'b00;
    bus.entradaDer[0] = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_der", bus.salidaDerecha, 0);
    chk("rst_izq", bus.salidaIzquierda, 0);
    chk("rst_fuente", bus.fuenteActiva, 0);
    chk("rst_camb", bus.cambiando, 0);

    // level latency from reset release
    rst_n = 1'b1;
    run(0, 1'b0, 60, 90);
    chk("lvl_rise", sube.size() >= 1 ? sube[0] : -1, DB + 3);
    chk("lvl_fall", baja.size() >= 1 ? baja[0] : -1, 60 + DB + 3);
    chk("lvl_camb", camb_seen, 0);
    chk("lvl_fuente", bus.fuenteActiva, 0);

    // glitch one short of the debounce, then exactly long enough
    run(0, 1'b1, DB - 1, 50);
    chk("glitch_pulses", sube.size(), 0);
    run(0, 1'b1, DB, 60);
    chk("hold_rise", sube.size() >= 1 ? sube[0] : -1, DB + 3);
    chk("hold_fall", baja.size() >= 1 ? baja[0] : -1, 2 * DB + 3);

    // source change 0 -> 2 with right held on both
    bus.entradaDer[0] = 1'b1;
    bus.entradaDer[2] = 1'b1;
    repeat (25) tick();
    chk("sw_pre_der", bus.salidaDerecha, 1);
    bus.selector = 2'd2;
    rise = -1;
    camb_cnt = 0;
    camb_last = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        chk("sw_fuente", bus.fuenteActiva, 2);
        chk("sw_camb", bus.cambiando, 1);
        chk("sw_der0", bus.salidaDerecha, 0);
      end
      if (bus.cambiando) begin
        camb_cnt++;
        camb_last = k;
      end
      if (bus.salidaDerecha && rise < 0) rise = k;
    end
    chk("sw_camb_len", camb_cnt, GC);
    chk("sw_camb_last", camb_last, GC);
    chk("sw_rise", rise, GC + DB + 1 + 1);
    bus.entradaDer[0] = 1'b0;
    bus.entradaDer[2] = 1'b0;

    // out-of-range selection maps to source 0
    bus.selector = 2'd3;
    tick();
    chk("oor_fuente", bus.fuenteActiva, 0);
    chk("oor_camb", bus.cambiando, 1);
    repeat (20) tick();
    camb_seen = 1'b0;
    bus.selector = 2'd0;
    repeat (10) begin
      tick();
      if (bus.cambiando) camb_seen = 1'b1;
    end
    bus.selector = 2'd3;
    repeat (10) begin
      tick();
      if (bus.cambiando) camb_seen = 1'b1;
    end
    chk("oor_noguard", camb_seen, 0);
    chk("oor_fuente2", bus.fuenteActiva, 0);
    bus.selector = 2'd0;
    repeat (5) tick();

    // auto-repeat
    bus.modo = 2'b10;
    run(0, 1'b0, 2000, 2040);
    expq.delete();
    t = DB + 3;
    expq.push_back(t);
    t = t + RD;
    while (t <= 2000 + DB + 2) begin
      expq.push_back(t);
      t = t + RPP;
    end
    chk("rep_count", sube.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk($sformatf("rep_at%0d", i), i < sube.size() ? sube[i] : -1,
          expq[i]);
      chk($sformatf("rep_w%0d", i), i < baja.size() ? baja[i] : -1,
          expq[i] + 1);
    end
    chk("rep_both", both1, 0);

    // one-shot
    bus.modo = 2'b01;
    run(0, 1'b0, 2000, 2040);
    chk("one_count", sube.size(), 1);
    chk("one_at", sube.size() >= 1 ? sube[0] : -1, DB + 3);
    chk("one_w", baja.size() >= 1 ? baja[0] : -1, DB + 4);

    // conflict, then release of left
    bus.modo = 2'b00;
    bus.entradaDer[0] = 1'b1;
    bus.entradaIzq[0] = 1'b1;
    anyout = 1'b0;
    repeat (40) begin
      tick();
      if (bus.salidaDerecha || bus.salidaIzquierda) anyout = 1'b1;
    end
    chk("conf_none", anyout, 0);
    bus.entradaIzq[0] = 1'b0;
    rise = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.salidaDerecha && rise < 0) rise = k;
    end
    chk("conf_release", rise, DB + 3);

    // asynchronous reset mid-hold
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_der", bus.salidaDerecha, 0);
    chk("arst_camb", bus.cambiando, 0);
    chk("arst_fuente", bus.fuenteActiva, 0);
    bus.entradaDer = '0;
    bus.entradaIzq = '0;
    repeat (2) tick();

    // random level-mode traffic on source 0 with noise elsewhere
    rst_n = 1'b1;
    hd.delete();
    hi.delete();
    md = 1'b0;
    mi = 1'b0;
    n = 0;
    while (n < 1500) begin
      len = $urandom_range(1, 40);
      dd = 1'($urandom_range(0, 1));
      ii = 1'($urandom_range(0, 1));
      bus.modo = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      for (int k = 0; k < len; k++) begin
        n++;
        bus.entradaDer[0] = dd;
        bus.entradaIzq[0] = ii;
        bus.entradaDer[1] = 1'($urandom);
        bus.entradaIzq[1] = 1'($urandom);
        bus.entradaDer[2] = 1'($urandom);
        bus.entradaIzq[2] = 1'($urandom);
        hd.push_back(dd);
        hi.push_back(ii);
        tick();
        expo = {mi & ~md, md & ~mi};
        chk("rnd_out", {bus.salidaIzquierda, bus.salidaDerecha}, expo);
        if (flips(1'b0, n, ~md)) md = ~md;
        if (flips(1'b1, n, ~mi)) mi = ~mi;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
